// File: rtl/instruction_encoder_loader.sv
// ----------------------------------------------------------------------------
// instruction_encoder_loader
//
// Program loader for instruction memory. It takes MIPS field tuples over a
// valid/ready handshake, packs each tuple into a 32-bit R, I or J instruction
// word, and writes the words to consecutive word addresses starting at 0.
//
// Ports
//   clk, rst          clock (rising edge) and synchronous active-high reset
//   start             one-cycle pulse: begin a new load at word address 0
//   finish            one-cycle pulse: end the current load
//   in_valid/in_ready field-tuple handshake
//   fmt               00=R, 01=I, 10=J, 11=illegal
//   opcode..jump      instruction fields
//   mem_we            one-cycle write strobe, asserted the cycle after acceptance
//   mem_addr          word address for the write
//   mem_wdata         encoded instruction word
//   word_count        number of words written in the current load
//   full              word_count == 2**ADDR_WIDTH
//   done              the load has been finished
//   err               sticky: an illegal fmt was seen in the current load
// ----------------------------------------------------------------------------
module instruction_encoder_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  finish,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            fmt,
    input  logic [5:0]            opcode,
    input  logic [4:0]            rs,
    input  logic [4:0]            rt,
    input  logic [4:0]            rd,
    input  logic [4:0]            shamt,
    input  logic [5:0]            funct,
    input  logic [15:0]           addr,
    input  logic [25:0]           jump,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  full,
    output logic                  done,
    output logic                  err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] FMT_R = 2'b00;
    localparam logic [1:0] FMT_I = 2'b01;
    localparam logic [1:0] FMT_J = 2'b10;

    // 2**ADDR_WIDTH expressed at the width of word_count
    localparam logic [ADDR_WIDTH:0] CAPACITY  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] COUNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [1:0]            state_reg;
    logic [1:0]            state_next;
    logic [ADDR_WIDTH:0]   word_count_reg;
    logic                  err_reg;
    logic                  mem_we_reg;
    logic [ADDR_WIDTH-1:0] mem_addr_reg;
    logic [31:0]           mem_wdata_reg;

    logic                  accept;
    logic                  fmt_illegal;
    logic                  write_fire;
    logic [31:0]           encoded_word;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign full     = (word_count_reg == CAPACITY);
    assign in_ready = (state_reg == ST_LOAD) && !full;

    // A beat that coincides with start is still handshaken but thrown away:
    // the restart owns address 0.
    assign accept      = in_valid && in_ready && !start;
    assign fmt_illegal = (fmt == 2'b11);
    assign write_fire  = accept && !fmt_illegal;

    // ------------------------------------------------------------------
    // Field packing
    // ------------------------------------------------------------------
    always_comb begin
        encoded_word = 32'h0;
        case (fmt)
            FMT_R:   encoded_word = {opcode, rs, rt, rd, shamt, funct};
            FMT_I:   encoded_word = {opcode, rs, rt, addr};
            FMT_J:   encoded_word = {opcode, jump};
            default: encoded_word = 32'h0;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM; start has priority over finish in every state
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (start) begin
                    state_next = ST_LOAD;
                end else if (finish) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_next = ST_LOAD;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            word_count_reg <= '0;
            err_reg        <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= 32'h0;
        end else begin
            state_reg  <= state_next;
            // Strobe is a single-cycle echo of a legal acceptance
            mem_we_reg <= write_fire;

            if (start) begin
                word_count_reg <= '0;
                err_reg        <= 1'b0;
            end else begin
                if (write_fire) begin
                    // The low bits of the count double as the write pointer;
                    // acceptance stops at full so they never wrap.
                    mem_addr_reg   <= word_count_reg[ADDR_WIDTH-1:0];
                    mem_wdata_reg  <= encoded_word;
                    word_count_reg <= word_count_reg + COUNT_ONE;
                end
                if (accept && fmt_illegal) begin
                    err_reg <= 1'b1;
                end
            end
        end
    end

    assign mem_we     = mem_we_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign word_count = word_count_reg;
    assign err        = err_reg;
    assign done       = (state_reg == ST_DONE);

endmodule

// File: tb/tb_instruction_encoder_loader.sv
// ----------------------------------------------------------------------------
// Bench for instruction_encoder_loader (ADDR_WIDTH=2, capacity 4 words).
// A behavioural model tracks loading/finished flags, a word counter, the
// sticky error and the expected write; every cycle the DUT outputs are
// compared against it. Directed scenarios are followed by random traffic.
// ----------------------------------------------------------------------------
module tb_instruction_encoder_loader;

    localparam int AW  = 2;
    localparam int CAP = 4;

    logic          clk = 1'b0;
    logic          rst, start, finish, in_valid;
    logic          in_ready;
    logic [1:0]    fmt;
    logic [5:0]    opcode, funct;
    logic [4:0]    rs, rt, rd, shamt;
    logic [15:0]   addr;
    logic [25:0]   jump;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [AW:0]   word_count;
    logic          full, done, err;

    always #5 clk = ~clk;

    instruction_encoder_loader #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .funct(funct), .addr(addr), .jump(jump),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .word_count(word_count), .full(full), .done(done), .err(err)
    );

    // Model state
    bit          m_loading, m_finished, m_err, m_we;
    int          m_count;
    logic [31:0] m_addr, m_wdata;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Instruction word from the field rules, using weights of bit positions
    function automatic logic [31:0] model_encode();
        logic [31:0] w;
        case (fmt)
            2'b00: w = 32'(opcode) * 32'h0400_0000 + 32'(rs) * 32'h0020_0000 +
                       32'(rt) * 32'h0001_0000 + 32'(rd) * 32'h0000_0800 +
                       32'(shamt) * 32'h0000_0040 + 32'(funct);
            2'b01: w = 32'(opcode) * 32'h0400_0000 + 32'(rs) * 32'h0020_0000 +
                       32'(rt) * 32'h0001_0000 + 32'(addr);
            default: w = 32'(opcode) * 32'h0400_0000 + 32'(jump);
        endcase
        return w;
    endfunction

    task automatic model_reset();
        m_loading = 0; m_finished = 0; m_err = 0; m_we = 0;
        m_count = 0; m_addr = 0; m_wdata = 0;
    endtask

    task automatic clear_inputs();
        rst = 0; start = 0; finish = 0; in_valid = 0;
    endtask

    task automatic rand_fields(input logic [1:0] f);
        fmt    = f;
        opcode = 6'($urandom);  rs    = 5'($urandom);
        rt     = 5'($urandom);  rd    = 5'($urandom);
        shamt  = 5'($urandom);  funct = 6'($urandom);
        addr   = 16'($urandom); jump  = 26'($urandom);
    endtask

    // One clock: check ready, advance the model, then check all outputs.
    task automatic cycle();
        bit ready;
        #1;
        ready = m_loading && (m_count < CAP);
        check_eq("in_ready", 32'(in_ready), 32'(ready));
        if (rst) begin
            model_reset();
        end else if (start) begin
            m_loading = 1; m_finished = 0; m_count = 0; m_err = 0; m_we = 0;
        end else begin
            m_we = 0;
            if (m_loading) begin
                if (in_valid && ready) begin
                    if (fmt == 2'b11) begin
                        m_err = 1;
                    end else begin
                        m_we = 1;
                        m_addr = 32'(m_count);
                        m_wdata = model_encode();
                        m_count++;
                    end
                end
                if (finish) begin
                    m_loading = 0; m_finished = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        check_eq("mem_we",     32'(mem_we),     32'(m_we));
        check_eq("mem_addr",   32'(mem_addr),   m_addr);
        check_eq("mem_wdata",  mem_wdata,       m_wdata);
        check_eq("word_count", 32'(word_count), 32'(m_count));
        check_eq("full",       32'(full),       32'(m_count == CAP));
        check_eq("done",       32'(done),       32'(m_finished));
        check_eq("err",        32'(err),        32'(m_err));
    endtask

    task automatic do_start();
        clear_inputs(); start = 1; cycle(); start = 0;
    endtask

    task automatic do_beat(input logic [1:0] f);
        rand_fields(f); in_valid = 1; cycle(); in_valid = 0;
    endtask

    initial begin
        clear_inputs();
        rand_fields(2'b00);
        rst = 1;
        @(posedge clk); #1;
        model_reset();
        cycle(); cycle();
        rst = 0;
        $display("[TB] reset: in_ready=%0b done=%0b err=%0b", in_ready, done, err);

        // R-format
        do_start();
        fmt = 2'b00; opcode = 0; rs = 1; rt = 2; rd = 3; shamt = 0; funct = 6'h20;
        in_valid = 1; cycle(); in_valid = 0;
        check_eq("r_wdata", mem_wdata, 32'h0022_1820);
        check_eq("r_addr", 32'(mem_addr), 0);
        check_eq("r_count", 32'(word_count), 1);
        $display("[TB] R beat: we=%0b addr=%0d wdata=%h", mem_we, mem_addr, mem_wdata);

        // I then J back-to-back
        do_start();
        rand_fields(2'b01); opcode = 8; rs = 1; rt = 2; addr = 16'h0005;
        in_valid = 1; cycle();
        check_eq("i_wdata", mem_wdata, 32'h2022_0005);
        check_eq("i_addr", 32'(mem_addr), 0);
        rand_fields(2'b10); opcode = 2; jump = 26'h000_0040;
        cycle(); in_valid = 0;
        check_eq("j_wdata", mem_wdata, 32'h0800_0040);
        check_eq("j_addr", 32'(mem_addr), 1);
        check_eq("j_we", 32'(mem_we), 1);
        cycle();
        check_eq("ij_count", 32'(word_count), 2);
        $display("[TB] I/J beats: count=%0d", word_count);

        // Illegal between legal beats
        do_start();
        do_beat(2'b00);
        do_beat(2'b11);
        check_eq("ill_we", 32'(mem_we), 0);
        check_eq("ill_err", 32'(err), 1);
        do_beat(2'b01);
        check_eq("ill_addr", 32'(mem_addr), 1);
        check_eq("ill_count", 32'(word_count), 2);
        $display("[TB] illegal beat: err=%0b count=%0d", err, word_count);

        // Fill to capacity, 5th beat held
        do_start();
        for (int i = 0; i < 5; i++) begin
            rand_fields(2'(i % 3)); in_valid = 1; cycle();
        end
        in_valid = 0;
        check_eq("full_flag", 32'(full), 1);
        check_eq("full_ready", 32'(in_ready), 0);
        check_eq("full_count", 32'(word_count), 4);
        finish = 1; cycle(); finish = 0;
        check_eq("full_done", 32'(done), 1);
        $display("[TB] full: count=%0d done=%0b", word_count, done);

        // finish together with the last beat, then restart
        do_start();
        do_beat(2'b00);
        do_beat(2'b11);
        rand_fields(2'b10); in_valid = 1; finish = 1; cycle(); clear_inputs();
        check_eq("fin_we", 32'(mem_we), 1);
        check_eq("fin_done", 32'(done), 1);
        check_eq("fin_addr", 32'(mem_addr), 1);
        do_start();
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_err", 32'(err), 0);
        check_eq("rst_count", 32'(word_count), 0);
        do_beat(2'b01);
        check_eq("restart_addr", 32'(mem_addr), 0);
        $display("[TB] finish+beat then restart: addr=%0d", mem_addr);

        // Reset mid-load
        do_start();
        do_beat(2'b00);
        rst = 1; cycle(); rst = 0;
        check_eq("midrst_we", 32'(mem_we), 0);
        check_eq("midrst_wdata", mem_wdata, 0);
        check_eq("midrst_ready", 32'(in_ready), 0);
        cycle();
        check_eq("midrst_we2", 32'(mem_we), 0);
        $display("[TB] reset mid-load: we=%0b count=%0d", mem_we, word_count);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 99) == 0);
            start    = ($urandom_range(0, 19) == 0);
            finish   = ($urandom_range(0, 14) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            rand_fields(($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2)));
            cycle();
        end
        clear_inputs();
        $display("[TB] random phase complete");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_encoder_loader.md
Name: instruction_encoder_loader

Overview:
Packs MIPS instruction fields (opcode, rs, rt, rd, shamt, funct, 16-bit immediate, 26-bit jump target) into 32-bit R/I/J instruction words, which the instruction decoder then splits apart again. Field tuples arrive over a valid/ready handshake. Each encoded word is written to consecutive instruction-memory addresses. Used as the program loader that fills instruction memory before the CPU runs.

Parameters:
ADDR_WIDTH, 8, instruction-memory word-address width; capacity 2**ADDR_WIDTH words

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
start  input  1  one-cycle pulse; begin a new load at word address 0
finish  input  1  one-cycle pulse; end the current load
in_valid  input  1  field tuple valid
in_ready  output  1  loader can accept a tuple this cycle
fmt  input  2  00=R, 01=I, 10=J, 11=illegal
opcode  input  6  instruction[31:26]
rs  input  5  R/I [25:21]
rt  input  5  R/I [20:16]
rd  input  5  R [15:11]
shamt  input  5  R [10:6]
funct  input  6  R [5:0]
addr  input  16  I [15:0]
jump  input  26  J [25:0]
mem_we  output  1  instruction-memory write strobe
mem_addr  output  ADDR_WIDTH  write word address
mem_wdata  output  32  encoded instruction
word_count  output  ADDR_WIDTH+1  words written in the current load
full  output  1  word_count == 2**ADDR_WIDTH
done  output  1  load finished
err  output  1  sticky: an illegal fmt was received in the current load

Behaviour:
- Reset (sync, rst=1 at the edge):
  - State goes to IDLE.
  - mem_we, mem_addr, mem_wdata, word_count, full, done and err all go to 0.
  - A pending write is cancelled; no strobe follows reset.
- FSM states: IDLE, LOAD, DONE.
  - IDLE: in_ready=0. start -> LOAD.
  - LOAD: in_ready = ~full. finish -> DONE. start -> restart LOAD.
  - DONE: in_ready=0, done=1. start -> LOAD.
- Entering LOAD, from any state via start:
  - word_count, write pointer, err and done are cleared.
  - full is recomputed, so it reads 0.
- A beat is accepted when in_valid & in_ready.
- Encoding is combinational on the accepted beat and registered into mem_wdata:
  - R: {opcode, rs, rt, rd, shamt, funct}
  - I: {opcode, rs, rt, addr}
  - J: {opcode, jump}
- Latency:
  - mem_we=1 for exactly one cycle, on the cycle after acceptance.
  - mem_addr carries the write pointer value at acceptance.
  - The pointer and word_count increment on that same edge.
  - Back-to-back beats give back-to-back writes at consecutive addresses.
- Illegal fmt=11:
  - The beat is consumed: in_ready stays high and the handshake completes.
  - No write occurs, the pointer is unchanged, and err is set to 1.
- Full:
  - When word_count reaches 2**ADDR_WIDTH, in_ready drops to 0 and no wrap occurs.
  - finish still moves the FSM to DONE.
- finish and an accepted beat in the same cycle: the beat is encoded and written, the FSM goes to DONE, and that final mem_we strobe still occurs.
- start and finish in the same cycle: start wins.
- start with an accepted beat in the same cycle: the beat is dropped and the load restarts at address 0.
- In IDLE and DONE, in_valid is ignored.
- Between writes: mem_we=0, while mem_addr and mem_wdata hold their last values.
- done stays 1 in DONE until the next start or rst.

Test Plan:
- R-format. Stimulus: rst, start, then a beat with fmt=00, opcode=0, rs=1, rt=2, rd=3, shamt=0, funct=0x20. Response: next cycle mem_we=1, mem_addr=0, mem_wdata=0x00221820; word_count=1.
- I and J back-to-back. Stimulus: beat fmt=01, opcode=8, rs=1, rt=2, addr=0x0005, immediately followed by beat fmt=10, opcode=2, jump=0x0000040. Response: writes 0x20220005 at address 0, then 0x08000040 at address 1, on consecutive cycles; word_count=2.
- Illegal format. Stimulus: a beat with fmt=11 between two legal beats. Response: in_ready stays 1, err=1, the legal beats land at addresses 0 and 1, word_count=2, and there is no strobe for the illegal beat.
- Full (ADDR_WIDTH=2). Stimulus: stream 5 beats. Response: 4 writes at addresses 0..3, then full=1 and in_ready=0; the 5th beat is held. Then finish gives done=1.
- finish with last beat, then restart. Stimulus: finish asserted in the same cycle as an accepted beat. Response: the write still occurs, the FSM goes to DONE, done=1. Then start gives done=0, err=0, word_count=0, and the next write goes to address 0.
- Reset mid-load. Stimulus: rst asserted in the cycle after an acceptance. Response: no mem_we on the following cycle; all outputs are 0 and the FSM is in IDLE.
